// File: rtl/alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_sequencer_if
// Bundles the sequencer's control, instruction-memory, issue and result
// signals so that the sequencer and its environment share one port.
//
//   start, prog_len             program launch request and length
//   busy, done, err             run status
//   imem_en, imem_addr          synchronous instruction memory read port
//   imem_rdata                  read data, valid the cycle after imem_en
//   exec_valid                  one-cycle issue strobe to decoder/ALU
//   exec_opcode, exec_operand   fields of the issued instruction
//   res_valid, res_ready        result handshake toward write-back
//
// modport master : the sequencer side
// modport slave  : the environment side (memory, decoder/ALU, write-back)
// -----------------------------------------------------------------------------
interface alu_sequencer_if #(
    parameter int OPCODE_WIDTH  = 3,
    parameter int OPERAND_WIDTH = 8,
    parameter int ADDR_WIDTH    = 8
);
    logic                                  start;
    logic [ADDR_WIDTH-1:0]                 prog_len;
    logic                                  busy;
    logic                                  done;
    logic                                  err;
    logic                                  imem_en;
    logic [ADDR_WIDTH-1:0]                 imem_addr;
    logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] imem_rdata;
    logic                                  exec_valid;
    logic [OPCODE_WIDTH-1:0]               exec_opcode;
    logic [OPERAND_WIDTH-1:0]              exec_operand;
    logic                                  res_valid;
    logic                                  res_ready;

    modport master (
        input  start, prog_len, imem_rdata, res_ready,
        output busy, done, err, imem_en, imem_addr,
               exec_valid, exec_opcode, exec_operand, res_valid
    );

    modport slave (
        output start, prog_len, imem_rdata, res_ready,
        input  busy, done, err, imem_en, imem_addr,
               exec_valid, exec_opcode, exec_operand, res_valid
    );
endinterface

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle program sequencer for the ALU datapath. Fetches instruction
// words ({opcode, operand}, opcode in the MSBs) from a synchronous program
// store, issues each one to the decoder/ALU as a one-cycle strobe and applies
// per-opcode timing: execute latency for ADD/MAC, a valid/ready result
// handshake toward write-back, and an exact-length stall for WAIT.
//
// Ports:
//   clk    in  clock, all state on the rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    alu_sequencer_if.master (see interface header for the signals)
//
// All outputs come from registers or from a decode of the state register;
// no input reaches an output combinationally.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; done pulses here after a program ends
// S_FETCH  | imem_en high, imem_addr = pc
// S_DECODE | memory data valid, latched into exec_opcode/exec_operand
// S_ISSUE  | exec_valid high for this cycle only; dispatch on opcode
// S_EXEC   | ALU latency count-down for ADD/MAC
// S_WB     | res_valid high until res_ready accepts the result
// S_WAIT   | stall for exactly operand cycles
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int OPCODE_WIDTH  = 3,
    parameter int OPERAND_WIDTH = 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int MAC_LATENCY   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.master bus
);

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_MAC  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_WAIT = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_SETB = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_SETD = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_SETE = OPCODE_WIDTH'(6);

    localparam int LAT_W = (MAC_LATENCY < 1) ? 1 : $clog2(MAC_LATENCY + 1);
    localparam int IW    = OPCODE_WIDTH + OPERAND_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_EXEC,
        S_WB,
        S_WAIT
    } state_t;

    state_t                   state;
    state_t                   state_nxt;

    logic [ADDR_WIDTH-1:0]    pc;
    logic [ADDR_WIDTH-1:0]    len_q;
    logic [LAT_W-1:0]         lat_cnt;
    logic [OPERAND_WIDTH-1:0] wait_cnt;
    logic [OPCODE_WIDTH-1:0]  op_q;
    logic [OPERAND_WIDTH-1:0] operand_q;
    logic                     err_q;
    logic                     done_q;

    // advance: the current instruction finishes this cycle (the NEXT action)
    logic                     advance;
    logic                     is_last;

    assign is_last = ((pc + ADDR_WIDTH'(1)) == len_q);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start && (bus.prog_len != '0)) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_ISSUE;
            S_ISSUE: begin
                case (op_q)
                    OP_ADD, OP_MAC: state_nxt = S_EXEC;
                    OP_WAIT: begin
                        if (operand_q != '0) begin
                            state_nxt = S_WAIT;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                    default: advance = 1'b1;
                endcase
            end
            S_EXEC: begin
                // counter reaches zero on this decrement
                if (lat_cnt == LAT_W'(1)) begin
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                if (bus.res_ready) begin
                    advance = 1'b1;
                end
            end
            S_WAIT: begin
                if (wait_cnt == OPERAND_WIDTH'(1)) begin
                    advance = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (advance) begin
            state_nxt = is_last ? S_IDLE : S_FETCH;
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        bus.imem_en      = (state == S_FETCH);
        bus.exec_valid   = (state == S_ISSUE);
        bus.res_valid    = (state == S_WB);
        bus.busy         = (state != S_IDLE);
        bus.imem_addr    = pc;
        bus.exec_opcode  = op_q;
        bus.exec_operand = operand_q;
        bus.err          = err_q;
        bus.done         = done_q;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            len_q     <= '0;
            lat_cnt   <= '0;
            wait_cnt  <= '0;
            op_q      <= '0;
            operand_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        len_q <= bus.prog_len;
                        pc    <= '0;
                        err_q <= 1'b0;
                        // an empty program completes immediately
                        if (bus.prog_len == '0) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    op_q      <= bus.imem_rdata[IW-1 -: OPCODE_WIDTH];
                    operand_q <= bus.imem_rdata[OPERAND_WIDTH-1:0];
                end
                S_ISSUE: begin
                    case (op_q)
                        OP_ADD:  lat_cnt  <= LAT_W'(1);
                        OP_MAC:  lat_cnt  <= LAT_W'(MAC_LATENCY);
                        OP_WAIT: wait_cnt <= operand_q;
                        OP_SETB, OP_SETD, OP_SETE: begin
                        end
                        default: err_q <= 1'b1;
                    endcase
                end
                S_EXEC: lat_cnt  <= lat_cnt - LAT_W'(1);
                S_WAIT: wait_cnt <= wait_cnt - OPERAND_WIDTH'(1);
                default: begin
                end
            endcase

            if (advance) begin
                if (is_last) begin
                    done_q <= 1'b1;
                end else begin
                    pc <= pc + ADDR_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    localparam int OW = 3;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int ML = 2;

    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_MAC  = 3'd2;
    localparam logic [2:0] OP_WAIT = 3'd3;
    localparam logic [2:0] OP_SETB = 3'd4;
    localparam logic [2:0] OP_SETD = 3'd5;
    localparam logic [2:0] OP_SETE = 3'd6;
    localparam logic [2:0] OP_BAD  = 3'd7;

    localparam int EV_FETCH = 0;
    localparam int EV_ISSUE = 1;
    localparam int EV_RES   = 2;
    localparam int EV_DONE  = 3;

    typedef struct {
        int kind;
        int cyc;
        int data;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   ntests;
    int   nfail;
    int   t0;
    ev_t  exp_q[$];

    logic [OW+DW-1:0] imem [0:255];

    alu_sequencer_if #(.OPCODE_WIDTH(OW), .OPERAND_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    alu_sequencer #(
        .OPCODE_WIDTH (OW),
        .OPERAND_WIDTH(DW),
        .ADDR_WIDTH   (AW),
        .MAC_LATENCY  (ML)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous program store
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= imem[bus.imem_addr];
    end

    function automatic string kname(input int k);
        case (k)
            EV_FETCH: return "fetch";
            EV_ISSUE: return "issue";
            EV_RES:   return "result";
            default:  return "done";
        endcase
    endfunction

    task automatic push_ev(input int k, input int c, input int d);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int k, input int d);
        ev_t e;
        ntests++;
        if (exp_q.size() == 0) begin
            nfail++;
            $display("FAIL unexpected_%s: cycle %0d data %0h, required no event", kname(k), cyc, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.data != d) begin
                nfail++;
                $display("FAIL %s_event: got %s @%0d data %0h, required %s @%0d data %0h",
                         kname(k), kname(k), cyc, d, kname(e.kind), e.cyc, e.data);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: cycle %0d got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.imem_en)                   check_ev(EV_FETCH, int'(bus.imem_addr));
            if (bus.exec_valid)                check_ev(EV_ISSUE, int'({bus.exec_opcode, bus.exec_operand}));
            if (bus.res_valid && bus.res_ready) check_ev(EV_RES, 0);
            if (bus.done)                      check_ev(EV_DONE, int'(bus.err));
        end
    end

    task automatic start_prog(input logic [AW-1:0] len, output int ts);
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.prog_len = len;
        ts           = cyc;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.prog_len = 8'hAA;
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            ntests++;
            nfail++;
            $display("FAIL drain_timeout: %0d events outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"},         int'(bus.busy),         0);
        chk({tag, "_done"},         int'(bus.done),         0);
        chk({tag, "_err"},          int'(bus.err),          0);
        chk({tag, "_imem_en"},      int'(bus.imem_en),      0);
        chk({tag, "_imem_addr"},    int'(bus.imem_addr),    0);
        chk({tag, "_exec_valid"},   int'(bus.exec_valid),   0);
        chk({tag, "_exec_opcode"},  int'(bus.exec_opcode),  0);
        chk({tag, "_exec_operand"}, int'(bus.exec_operand), 0);
        chk({tag, "_res_valid"},    int'(bus.res_valid),    0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ntests        = 0;
        nfail         = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.prog_len  = '0;
        bus.res_ready = 1'b0;
        bus.imem_rdata = '0;
        for (int i = 0; i < 256; i++) imem[i] = '0;

        // reset state
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // empty program: done one cycle after start, never busy, no fetch
        start_prog(8'd0, t0);
        push_ev(EV_DONE, t0 + 1, 0);
        @(negedge clk);
        chk("busy_len0", int'(bus.busy), 0);
        wait_drain(20);

        // [SETB, SETD, SETE]; a start and prog_len change mid-run are ignored
        imem[0] = {OP_SETB, 8'h12};
        imem[1] = {OP_SETD, 8'h34};
        imem[2] = {OP_SETE, 8'h56};
        start_prog(8'd3, t0);
        push_ev(EV_FETCH, t0 + 1, 0);
        push_ev(EV_ISSUE, t0 + 3, 'h412);
        push_ev(EV_FETCH, t0 + 4, 1);
        push_ev(EV_ISSUE, t0 + 6, 'h534);
        push_ev(EV_FETCH, t0 + 7, 2);
        push_ev(EV_ISSUE, t0 + 9, 'h656);
        push_ev(EV_DONE,  t0 + 10, 0);
        repeat (3) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.prog_len = 8'd1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        to_cycle(t0 + 9);
        chk("busy_during_prog", int'(bus.busy), 1);
        to_cycle(t0 + 10);
        chk("busy_falls_with_done", int'(bus.busy), 0);
        wait_drain(40);

        // [MAC] with write-back stalled: res_valid holds from t0+6 to acceptance
        imem[0] = {OP_MAC, 8'h3C};
        bus.res_ready = 1'b0;
        start_prog(8'd1, t0);
        push_ev(EV_FETCH, t0 + 1, 0);
        push_ev(EV_ISSUE, t0 + 3, 'h23C);
        push_ev(EV_RES,   t0 + 9, 0);
        push_ev(EV_DONE,  t0 + 10, 0);
        while (cyc < t0 + 9) begin
            @(posedge clk);
            #1;
            if (cyc == t0 + 9) bus.res_ready = 1'b1;
            @(negedge clk);
            chk("res_valid_mac", int'(bus.res_valid), (cyc >= t0 + 6) ? 1 : 0);
        end
        to_cycle(t0 + 10);
        chk("res_valid_after_accept", int'(bus.res_valid), 0);
        wait_drain(40);

        // [WAIT 5, ADD] with res_ready held high
        imem[0] = {OP_WAIT, 8'h05};
        imem[1] = {OP_ADD,  8'h11};
        bus.res_ready = 1'b1;
        start_prog(8'd2, t0);
        push_ev(EV_FETCH, t0 + 1, 0);
        push_ev(EV_ISSUE, t0 + 3, 'h305);
        push_ev(EV_FETCH, t0 + 9, 1);
        push_ev(EV_ISSUE, t0 + 11, 'h111);
        push_ev(EV_RES,   t0 + 13, 0);
        push_ev(EV_DONE,  t0 + 14, 0);
        wait_drain(60);

        // [unknown, SETB]: err sets after the first issue and stays set
        imem[0] = {OP_BAD,  8'h55};
        imem[1] = {OP_SETB, 8'h01};
        start_prog(8'd2, t0);
        push_ev(EV_FETCH, t0 + 1, 0);
        push_ev(EV_ISSUE, t0 + 3, 'h755);
        push_ev(EV_FETCH, t0 + 4, 1);
        push_ev(EV_ISSUE, t0 + 6, 'h401);
        push_ev(EV_DONE,  t0 + 7, 1);
        to_cycle(t0 + 3);
        chk("err_before_issue", int'(bus.err), 0);
        to_cycle(t0 + 4);
        chk("err_after_issue", int'(bus.err), 1);
        wait_drain(40);
        chk("err_sticky_idle", int'(bus.err), 1);

        // new start clears err; WAIT 0 behaves as a three-cycle no-op
        imem[0] = {OP_WAIT, 8'h00};
        start_prog(8'd1, t0);
        push_ev(EV_FETCH, t0 + 1, 0);
        push_ev(EV_ISSUE, t0 + 3, 'h300);
        push_ev(EV_DONE,  t0 + 4, 0);
        @(negedge clk);
        chk("err_cleared_on_start", int'(bus.err), 0);
        wait_drain(40);

        // reset during EXEC of a MAC aborts immediately
        imem[0] = {OP_MAC, 8'h77};
        start_prog(8'd1, t0);
        push_ev(EV_FETCH, t0 + 1, 0);
        push_ev(EV_ISSUE, t0 + 3, 'h277);
        to_cycle(t0 + 4);
        chk("busy_in_exec", int'(bus.busy), 1);
        chk("events_before_abort", exp_q.size(), 0);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("res_valid_after_abort", int'(bus.res_valid), 0);
        imem[0] = {OP_SETB, 8'h09};
        start_prog(8'd1, t0);
        push_ev(EV_FETCH, t0 + 1, 0);
        push_ev(EV_ISSUE, t0 + 3, 'h409);
        push_ev(EV_DONE,  t0 + 4, 0);
        wait_drain(40);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
